id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined CPU: registers decoded instruction fields from ID and produces the final ALU operands and control for the EX-stage ALU. Resolves data hazards in the same block:
- forwarding from EX/MEM and MEM/WB;
- same-cycle write-back bypass of the register-file read;
- load-use stall with bubble insertion;
- branch flush.

---
 rtl/id_ex_stage_pkg.sv | 27 ++
 rtl/id_ex_stage_if.sv | 44 ++++
 rtl/id_ex_stage_forward_unit.sv | 26 ++
 rtl/id_ex_stage.sv | 73 +++++++
 tb/tb_id_ex_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU codes, forward-select encoding and control bundle for the ID/EX stage.
package id_ex_stage_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0100, ALU_OR   = 4'b0101,
        ALU_NOR  = 4'b0110, ALU_XOR  = 4'b0111, ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001,
        ALU_SLLV = 4'b1010, ALU_SRAV = 4'b1011, ALU_SLL  = 4'b1100, ALU_SRL  = 4'b1101,
        ALU_SRLV = 4'b1110, ALU_SRA  = 4'b1111
    } alu_ctr_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [3:0] alu_ctr;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                 mem_to_reg: 1'b0, alu_ctr: ALU_ADD};
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_if: ID inputs, EX/MEM and MEM/WB writer ports, and EX-side outputs of the ID/EX stage.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_use_rs, id_use_rt;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]        id_shamt;
    logic [3:0]        id_alu_ctr;
    logic              id_alu_src_imm, id_alu_src_shamt;
    logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic              flush;
    logic              mem_reg_write, wb_reg_write;
    logic [REG_AW-1:0] mem_rd, wb_rd;
    logic [DATA_W-1:0] mem_result, wb_data;
    logic              stall_id;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [REG_AW-1:0] ex_rd;
    logic [3:0]        ex_alu_ctr;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [DATA_W-1:0] ex_alu_a, ex_alu_b, ex_store_data;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_rs_data, id_rt_data,
               id_imm, id_shamt, id_alu_ctr, id_alu_src_imm, id_alu_src_shamt, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, flush, mem_reg_write, mem_rd, mem_result,
               wb_reg_write, wb_rd, wb_data,
        input  stall_id, ex_valid, ex_pc, ex_rd, ex_alu_ctr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_a, ex_alu_b, ex_store_data
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_rs_data, id_rt_data,
               id_imm, id_shamt, id_alu_ctr, id_alu_src_imm, id_alu_src_shamt, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, flush, mem_reg_write, mem_rd, mem_result,
               wb_reg_write, wb_rd, wb_data,
        output stall_id, ex_valid, ex_pc, ex_rd, ex_alu_ctr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_a, ex_alu_b, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: picks the newest in-flight value of one source register (MEM over WB over captured).
module forward_unit
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] src_val,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);
    fwd_sel_e sel;

    always_comb begin
        sel  = (src == '0) ? FWD_REG :
               (mem_reg_write && mem_rd == src) ? FWD_MEM :
               (wb_reg_write && wb_rd == src) ? FWD_WB : FWD_REG;
        data = (sel == FWD_MEM) ? mem_result : (sel == FWD_WB) ? wb_data : src_val;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB bypass, load-use stall, flush bubbles and EX forwarding.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic    clk,
    input logic    reset,
    id_ex_if.slave bus
);
    typedef struct packed {
        ctrl_t             ctrl;
        logic [31:0]       pc;
        logic [REG_AW-1:0] rd, rs, rt;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] rs_val, rt_val, imm;
        logic              src_imm, src_shamt;
    } stage_t;

    localparam stage_t BUBBLE_STAGE = '{ctrl: BUBBLE, default: '0};

    stage_t            stage_q, stage_d;
    logic              hazard;
    logic [DATA_W-1:0] rs_cap, rt_cap, fwd_rs, fwd_rt;

    always_comb begin
        hazard  = stage_q.ctrl.valid && stage_q.ctrl.mem_read && stage_q.rd != '0 &&
                  ((bus.id_use_rs && bus.id_rs == stage_q.rd) || (bus.id_use_rt && bus.id_rt == stage_q.rd));
        // register file is written late in the cycle, so a same-cycle WB must be bypassed here
        rs_cap  = (bus.wb_reg_write && bus.wb_rd == bus.id_rs && bus.id_rs != '0) ? bus.wb_data : bus.id_rs_data;
        rt_cap  = (bus.wb_reg_write && bus.wb_rd == bus.id_rt && bus.id_rt != '0) ? bus.wb_data : bus.id_rt_data;
        stage_d = (bus.flush || hazard) ? BUBBLE_STAGE : stage_t'{
            ctrl: ctrl_t'{valid: bus.id_valid, reg_write: bus.id_reg_write && bus.id_valid,
                          mem_read: bus.id_mem_read && bus.id_valid, mem_write: bus.id_mem_write && bus.id_valid,
                          mem_to_reg: bus.id_mem_to_reg && bus.id_valid, alu_ctr: bus.id_alu_ctr},
            pc: bus.id_pc, rd: bus.id_rd, rs: bus.id_rs, rt: bus.id_rt, shamt: bus.id_shamt,
            rs_val: rs_cap, rt_val: rt_cap, imm: bus.id_imm,
            src_imm: bus.id_alu_src_imm, src_shamt: bus.id_alu_src_shamt};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stage_q <= '0;
        else       stage_q <= stage_d;
    end

    forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src(stage_q.rs), .src_val(stage_q.rs_val),
        .mem_reg_write(bus.mem_reg_write), .mem_rd(bus.mem_rd), .mem_result(bus.mem_result),
        .wb_reg_write(bus.wb_reg_write), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
        .data(fwd_rs)
    );

    forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src(stage_q.rt), .src_val(stage_q.rt_val),
        .mem_reg_write(bus.mem_reg_write), .mem_rd(bus.mem_rd), .mem_result(bus.mem_result),
        .wb_reg_write(bus.wb_reg_write), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
        .data(fwd_rt)
    );

    assign bus.stall_id      = hazard && bus.id_valid && !bus.flush;
    assign bus.ex_valid      = stage_q.ctrl.valid;
    assign bus.ex_pc         = stage_q.pc;
    assign bus.ex_rd         = stage_q.rd;
    assign bus.ex_alu_ctr    = stage_q.ctrl.alu_ctr;
    assign bus.ex_reg_write  = stage_q.ctrl.reg_write;
    assign bus.ex_mem_read   = stage_q.ctrl.mem_read;
    assign bus.ex_mem_write  = stage_q.ctrl.mem_write;
    assign bus.ex_mem_to_reg = stage_q.ctrl.mem_to_reg;
    assign bus.ex_alu_a      = stage_q.src_shamt ? DATA_W'(stage_q.shamt) : fwd_rs;
    assign bus.ex_alu_b      = stage_q.src_imm ? stage_q.imm : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table vectors, hazard/flush/reset sequences and a randomized run against a reference model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    id_ex_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        bit [4:0]  rs, rt, shamt;
        bit [31:0] rs_data, rt_data, imm;
        bit        src_imm, src_shamt;
        bit [3:0]  ctr;
        bit        mem_rw;
        bit [4:0]  mem_rd;
        bit [31:0] mem_result;
        bit        wb_rw;
        bit [4:0]  wb_rd;
        bit [31:0] wb_data;
        bit [31:0] exp_a, exp_b, exp_st;
    } vec_t;

    typedef struct {
        bit        valid, rw, mr, mw, m2r, si, ss;
        bit [3:0]  ctr;
        bit [31:0] pc, rsv, rtv, imm;
        bit [4:0]  rd, rs, rt, shamt;
    } ex_m_t;

    ex_m_t m, mn;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.id_use_rs = 0; bus.id_use_rt = 0; bus.id_rs_data = 0; bus.id_rt_data = 0;
        bus.id_imm = 0; bus.id_shamt = 0; bus.id_alu_ctr = 0; bus.id_alu_src_imm = 0;
        bus.id_alu_src_shamt = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
        bus.id_mem_write = 0; bus.id_mem_to_reg = 0; bus.flush = 0;
        bus.mem_reg_write = 0; bus.mem_rd = 0; bus.mem_result = 0;
        bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_data = 0;
    endtask

    task automatic present_load(bit [4:0] rd);
        idle();
        bus.id_valid = 1; bus.id_pc = 32'h100; bus.id_rd = rd; bus.id_rs = 1; bus.id_use_rs = 1;
        bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_mem_to_reg = 1;
    endtask

    task automatic present_consumer(bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
        idle();
        bus.id_valid = 1; bus.id_pc = 32'h104; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_use_rs = 1; bus.id_use_rt = 1; bus.id_reg_write = 1; bus.id_rs_data = 32'h11;
    endtask

    // newest writer wins; $0 reads whatever was captured
    function automatic bit [31:0] newest(bit [4:0] r, bit [31:0] cap);
        bit        en[2];
        bit [4:0]  dst[2];
        bit [31:0] val[2];
        en  = '{bus.mem_reg_write, bus.wb_reg_write};
        dst = '{bus.mem_rd, bus.wb_rd};
        val = '{bus.mem_result, bus.wb_data};
        if (r == 0) return cap;
        for (int k = 0; k < 2; k++) if (en[k] && dst[k] == r) return val[k];
        return cap;
    endfunction

    function automatic bit model_hazard();
        return m.valid && m.mr && m.rd != 0 &&
               ((bus.id_use_rs && bus.id_rs == m.rd) || (bus.id_use_rt && bus.id_rt == m.rd));
    endfunction

    function automatic ex_m_t model_next();
        ex_m_t n = '{default: 0};
        bit    v = bus.id_valid;
        if (bus.flush || model_hazard()) return n;
        n.valid = v; n.rw = bus.id_reg_write & v; n.mr = bus.id_mem_read & v;
        n.mw = bus.id_mem_write & v; n.m2r = bus.id_mem_to_reg & v; n.ctr = bus.id_alu_ctr;
        n.pc = bus.id_pc; n.rd = bus.id_rd; n.rs = bus.id_rs; n.rt = bus.id_rt; n.shamt = bus.id_shamt;
        n.imm = bus.id_imm; n.si = bus.id_alu_src_imm; n.ss = bus.id_alu_src_shamt;
        n.rsv = (bus.wb_reg_write && bus.wb_rd == bus.id_rs && bus.id_rs != 0) ? bus.wb_data : bus.id_rs_data;
        n.rtv = (bus.wb_reg_write && bus.wb_rd == bus.id_rt && bus.id_rt != 0) ? bus.wb_data : bus.id_rt_data;
        return n;
    endfunction

    task automatic check_model();
        bit [31:0] ea, eb, es;
        chk("rnd_stall", 32'(bus.stall_id), 32'(model_hazard() && bus.id_valid && !bus.flush));
        chk("rnd_valid", 32'(bus.ex_valid), 32'(m.valid));
        chk("rnd_rd", 32'(bus.ex_rd), 32'(m.rd));
        chk("rnd_ctr", 32'(bus.ex_alu_ctr), 32'(m.ctr));
        chk("rnd_ctrl", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}),
            32'({m.rw, m.mr, m.mw, m.m2r}));
        if (m.valid) begin
            es = newest(m.rt, m.rtv);
            ea = m.ss ? {27'b0, m.shamt} : newest(m.rs, m.rsv);
            eb = m.si ? m.imm : es;
            chk("rnd_pc", bus.ex_pc, m.pc);
            chk("rnd_alu_a", bus.ex_alu_a, ea);
            chk("rnd_alu_b", bus.ex_alu_b, eb);
            chk("rnd_store", bus.ex_store_data, es);
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{rs:3, rt:4, shamt:0, rs_data:1, rt_data:2, imm:0, src_imm:0, src_shamt:0, ctr:4'h0,
                    mem_rw:1, mem_rd:3, mem_result:32'h10, wb_rw:0, wb_rd:0, wb_data:0,
                    exp_a:32'h10, exp_b:2, exp_st:2};
        vecs[1] = '{rs:3, rt:4, shamt:0, rs_data:1, rt_data:2, imm:0, src_imm:0, src_shamt:0, ctr:4'h0,
                    mem_rw:1, mem_rd:3, mem_result:32'h10, wb_rw:1, wb_rd:3, wb_data:32'h20,
                    exp_a:32'h10, exp_b:2, exp_st:2};
        vecs[2] = '{rs:0, rt:0, shamt:0, rs_data:0, rt_data:0, imm:0, src_imm:0, src_shamt:0, ctr:4'h0,
                    mem_rw:1, mem_rd:0, mem_result:32'hFFFF, wb_rw:1, wb_rd:0, wb_data:32'hEEEE,
                    exp_a:0, exp_b:0, exp_st:0};
        vecs[3] = '{rs:0, rt:2, shamt:4, rs_data:0, rt_data:1, imm:0, src_imm:0, src_shamt:1, ctr:4'hC,
                    mem_rw:0, mem_rd:0, mem_result:0, wb_rw:0, wb_rd:0, wb_data:0,
                    exp_a:4, exp_b:1, exp_st:1};
        vecs[4] = '{rs:1, rt:6, shamt:0, rs_data:100, rt_data:0, imm:8, src_imm:1, src_shamt:0, ctr:4'h0,
                    mem_rw:0, mem_rd:0, mem_result:0, wb_rw:1, wb_rd:6, wb_data:32'hAB,
                    exp_a:100, exp_b:8, exp_st:32'hAB};
        vecs[5] = '{rs:5, rt:5, shamt:0, rs_data:9, rt_data:9, imm:0, src_imm:0, src_shamt:0, ctr:4'h7,
                    mem_rw:1, mem_rd:6, mem_result:32'h66, wb_rw:1, wb_rd:5, wb_data:32'h77,
                    exp_a:32'h77, exp_b:32'h77, exp_st:32'h77};

        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(bus.ex_valid), 0);
        chk("reset_pc", bus.ex_pc, 0);
        chk("reset_ctr", 32'(bus.ex_alu_ctr), 0);
        chk("reset_stall", 32'(bus.stall_id), 0);
        chk("reset_alu_a", bus.ex_alu_a, 0);
        chk("reset_alu_b", bus.ex_alu_b, 0);
        reset = 0;

        foreach (vecs[i]) begin
            @(negedge clk);
            idle();
            bus.id_valid = 1; bus.id_pc = 32'h200 + 32'(i * 4); bus.id_rd = 1;
            bus.id_rs = vecs[i].rs; bus.id_rt = vecs[i].rt; bus.id_shamt = vecs[i].shamt;
            bus.id_use_rs = 1; bus.id_use_rt = 1;
            bus.id_rs_data = vecs[i].rs_data; bus.id_rt_data = vecs[i].rt_data; bus.id_imm = vecs[i].imm;
            bus.id_alu_src_imm = vecs[i].src_imm; bus.id_alu_src_shamt = vecs[i].src_shamt;
            bus.id_alu_ctr = vecs[i].ctr;
            @(posedge clk);
            @(negedge clk);
            idle();
            bus.mem_reg_write = vecs[i].mem_rw; bus.mem_rd = vecs[i].mem_rd; bus.mem_result = vecs[i].mem_result;
            bus.wb_reg_write = vecs[i].wb_rw; bus.wb_rd = vecs[i].wb_rd; bus.wb_data = vecs[i].wb_data;
            #1;
            chk($sformatf("vec%0d_alu_a", i), bus.ex_alu_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_alu_b", i), bus.ex_alu_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_store", i), bus.ex_store_data, vecs[i].exp_st);
            chk($sformatf("vec%0d_ctr", i), 32'(bus.ex_alu_ctr), 32'(vecs[i].ctr));
        end

        // load-use: one bubble, then the consumer gets the load value from WB
        @(negedge clk); present_load(5);
        @(posedge clk);
        @(negedge clk); present_consumer(1, 5, 6);
        #1 chk("lu_stall", 32'(bus.stall_id), 1);
        @(posedge clk);
        @(negedge clk);
        chk("lu_bubble_valid", 32'(bus.ex_valid), 0);
        chk("lu_bubble_rw", 32'(bus.ex_reg_write), 0);
        chk("lu_stall_released", 32'(bus.stall_id), 0);
        bus.mem_reg_write = 1; bus.mem_rd = 5;
        @(posedge clk);
        @(negedge clk);
        idle();
        bus.wb_reg_write = 1; bus.wb_rd = 5; bus.wb_data = 32'hCAFE;
        #1;
        chk("lu_consumer_valid", 32'(bus.ex_valid), 1);
        chk("lu_consumer_rd", 32'(bus.ex_rd), 6);
        chk("lu_fwd_b", bus.ex_alu_b, 32'hCAFE);

        // flush wins over a load-use hazard
        @(negedge clk); present_load(5);
        @(posedge clk);
        @(negedge clk); present_consumer(5, 2, 6); bus.flush = 1;
        #1 chk("flush_stall", 32'(bus.stall_id), 0);
        @(posedge clk);
        @(negedge clk); idle();
        chk("flush_bubble_valid", 32'(bus.ex_valid), 0);
        chk("flush_bubble_rd", 32'(bus.ex_rd), 0);

        // same-cycle WB bypass into the captured value
        @(negedge clk); idle();
        bus.id_valid = 1; bus.id_rs = 7; bus.id_use_rs = 1; bus.id_rs_data = 0;
        bus.wb_reg_write = 1; bus.wb_rd = 7; bus.wb_data = 32'h55;
        @(posedge clk);
        @(negedge clk); idle();
        #1 chk("wb_bypass_a", bus.ex_alu_a, 32'h55);

        // asynchronous reset during a stall
        @(negedge clk); present_load(5);
        @(posedge clk);
        @(negedge clk); present_consumer(5, 5, 6);
        #1 chk("rst_pre_stall", 32'(bus.stall_id), 1);
        reset = 1;
        #1;
        chk("rst_stall", 32'(bus.stall_id), 0);
        chk("rst_valid", 32'(bus.ex_valid), 0);
        chk("rst_ctr", 32'(bus.ex_alu_ctr), 0);
        chk("rst_ctrl", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}), 0);
        @(negedge clk); idle(); reset = 0;
        m = '{default: 0};

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.id_valid = ($urandom_range(0, 9) < 8); bus.id_pc = $urandom;
            bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_rd = 5'($urandom_range(0, 3));
            bus.id_use_rs = 1'($urandom); bus.id_use_rt = 1'($urandom);
            bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
            bus.id_shamt = 5'($urandom); bus.id_alu_ctr = 4'($urandom);
            bus.id_alu_src_imm = 1'($urandom); bus.id_alu_src_shamt = ($urandom_range(0, 3) == 0);
            bus.id_reg_write = 1'($urandom); bus.id_mem_read = ($urandom_range(0, 2) == 0);
            bus.id_mem_write = 1'($urandom); bus.id_mem_to_reg = 1'($urandom);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.mem_reg_write = 1'($urandom); bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_result = $urandom;
            bus.wb_reg_write = 1'($urandom); bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_data = $urandom;
            #1 check_model();
            mn = model_next();
            @(posedge clk);
            m = mn;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
